// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage core: load-use stalls,
// branch fetch hold, wrong-path squash and the MDU start/done handshake.
module pipe_hazard_ctrl #(
    parameter int unsigned BR_SLOTS    = 1,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic       id_is_mdu,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       imem_ready,
    input  logic       mdu_done,
    output logic       pc_write,
    output logic       hazard,
    output logic       branch_bubble,
    output logic       flush,
    output logic       idex_bubble,
    output logic       mdu_start,
    output logic       mdu_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_WAIT  = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] BR_INIT = 8'(BR_SLOTS - 1);
    localparam logic [7:0] TO_LAST = 8'(MDU_TIMEOUT - 1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       err_q;
    logic       err_nxt;
    logic       load_use;

    logic       pc_w;
    logic       haz;
    logic       bb;
    logic       fl;
    logic       ib;
    logic       ms;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) ||
                       (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_w    = 1'b1;
        haz     = 1'b0;
        bb      = 1'b0;
        fl      = 1'b0;
        ib      = 1'b0;
        ms      = 1'b0;
        nxt     = cur;
        cnt_nxt = cnt;
        err_nxt = err_q;
        unique case (cur)
            IDLE: begin
                if (ex_branch_taken) begin
                    fl = 1'b1;
                    ib = 1'b1;
                end else if (load_use) begin
                    haz  = 1'b1;
                    pc_w = 1'b0;
                    ib   = 1'b1;
                end else if (id_is_mdu) begin
                    ms      = 1'b1;
                    haz     = 1'b1;
                    pc_w    = 1'b0;
                    cnt_nxt = 8'd0;
                    nxt     = MDU_WAIT;
                end else if (id_is_branch) begin
                    cnt_nxt = BR_INIT;
                    nxt     = BR_WAIT;
                end else if (!imem_ready) begin
                    pc_w = 1'b0;
                    fl   = 1'b1;
                end
            end
            BR_WAIT: begin
                bb   = 1'b1;
                pc_w = 1'b0;
                ib   = 1'b1;
                // A taken branch ends the hold early and redirects the PC.
                if (ex_branch_taken) begin
                    fl   = 1'b1;
                    pc_w = 1'b1;
                    bb   = 1'b0;
                    nxt  = IDLE;
                end else if (cnt == 8'd0) begin
                    nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            MDU_WAIT: begin
                haz  = 1'b1;
                pc_w = 1'b0;
                ib   = 1'b1;
                if (mdu_done) begin
                    nxt = IDLE;
                end else if (cnt == TO_LAST) begin
                    err_nxt = 1'b1;
                    nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= IDLE;
            cnt   <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cur   <= nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign pc_write      = rst_n & pc_w;
    assign hazard        = rst_n & haz;
    assign branch_bubble = rst_n & bb;
    assign flush         = rst_n & fl;
    assign idex_bubble   = rst_n & ib;
    assign mdu_start     = rst_n & ms;
    assign mdu_err       = rst_n & err_q;
    assign state         = cur;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It drives the stall, bubble and flush controls of the IF/ID register (`hazard`, `BranchBubble`, `flush`), the PC write enable, and the ID/EX bubble. It detects load-use hazards, holds fetch while a branch resolves, and squashes wrong-path instructions on a taken branch. It also sequences the multi-cycle multiply/divide unit through a start/done handshake with a timeout.

## Interface
- `BR_SLOTS`, default 1: cycles fetch is held after a branch leaves ID (1..7).
- `MDU_TIMEOUT`, default 64: maximum cycles to wait for `mdu_done` (2..255).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `id_is_branch` in 1: the ID instruction is a branch or jump.
- `id_is_mdu` in 1: the ID instruction is mult/div.
- `ex_memread` in 1: the EX instruction is a load.
- `ex_rt` in 5: destination of the EX load.
- `ex_branch_taken` in 1: the branch in EX resolved taken.
- `imem_ready` in 1: instruction memory delivered a valid word this cycle.
- `mdu_done` in 1: MDU result valid (one-cycle pulse).
- `pc_write` out 1: PC update enable.
- `hazard` out 1: hold IF/ID.
- `branch_bubble` out 1: hold IF/ID during branch resolution.
- `flush` out 1: load a nop into IF/ID.
- `idex_bubble` out 1: load a nop into ID/EX.
- `mdu_start` out 1: one-cycle MDU start pulse.
- `mdu_err` out 1: sticky timeout flag.
- `state` out 2: current FSM state, for debug.

## Operation
- States: IDLE=0, BR_WAIT=1, MDU_WAIT=2. Register `cnt` is 8 bits.
- Outputs are Mealy (current state plus inputs). While `rst_n`=0, every output is 0, the FSM is in IDLE, `cnt`=0 and `mdu_err`=0.
- The load-use condition is `ex_memread` && `ex_rt`≠0 && (`ex_rt`==`id_rs` || (`id_uses_rt` && `ex_rt`==`id_rt`)).
- Default outputs: `pc_write`=1, all other outputs 0.
- IDLE, evaluated in priority order:
  1. `ex_branch_taken`: `flush`=1, `idex_bubble`=1, `pc_write`=1 (the PC takes the target). Stay in IDLE.
  2. Load-use: `hazard`=1, `pc_write`=0, `idex_bubble`=1. Stay in IDLE; this re-evaluates every cycle.
  3. `id_is_mdu`: `mdu_start`=1, `hazard`=1, `pc_write`=0. Set `cnt`=0 and go to MDU_WAIT.
  4. `id_is_branch`: the branch advances; set `cnt`=BR_SLOTS-1 and go to BR_WAIT.
  5. `imem_ready`=0: `pc_write`=0, `flush`=1.
- BR_WAIT:
  - Outputs `branch_bubble`=1, `pc_write`=0, `idex_bubble`=1.
  - If `ex_branch_taken`: override with `flush`=1, `pc_write`=1, `branch_bubble`=0, and go to IDLE immediately, regardless of `cnt`.
  - Else if `cnt`==0: go to IDLE.
  - Else decrement `cnt`.
- MDU_WAIT:
  - Outputs `hazard`=1, `pc_write`=0, `idex_bubble`=1.
  - On `mdu_done`: go to IDLE, with `hazard` still 1 in that cycle.
  - Else if `cnt`==MDU_TIMEOUT-1: set `mdu_err`=1 and go to IDLE.
  - Else increment `cnt`.
- Simultaneous `mdu_done` and timeout in the same cycle: done wins and `mdu_err` is not set.
- `ex_branch_taken` while in MDU_WAIT is ignored; no branch can be in EX behind a stalled MDU instruction.
- `mdu_err` clears only on reset.
- `mdu_start` is never asserted outside the IDLE→MDU_WAIT transition cycle.

## Timing
- Load-use stall: exactly 1 cycle per hazard, combinational in the detecting cycle; no extra latency.
- Branch hold:
  - Not taken: BR_SLOTS cycles after the branch leaves ID.
  - Taken: the hold ends in the cycle `ex_branch_taken` is seen, with one flush cycle.
- MDU: `mdu_start` is asserted in cycle 0. Stall lasts until the cycle `mdu_done` is seen, inclusive. Fetch resumes on the next cycle.
- State and `cnt` update on the rising `clk` edge. `rst_n` deassertion is sampled synchronously by the first edge.
- Reset mid-stall returns to IDLE immediately. `hazard`, `pc_write`, `mdu_start` and all other outputs drop to 0 while `rst_n`=0.

## Test plan
- **Load-use:**
  - Stimulus: `ex_memread`=1, `ex_rt`=5, `id_rs`=5.
  - Required: `hazard`=1, `pc_write`=0, `idex_bubble`=1 for 1 cycle.
  - Repeat with `ex_rt`=0: no stall.
  - Repeat with `id_uses_rt`=0 and `id_rt`=5 (rs not matching): no stall.
- **Branch, not taken, BR_SLOTS=2:**
  - Stimulus: `id_is_branch` pulse.
  - Required: `branch_bubble`=1 for exactly 2 cycles, then `pc_write`=1; `flush` stays 0.
- **Branch taken during BR_WAIT:**
  - Stimulus: `ex_branch_taken`=1 in the first BR_WAIT cycle.
  - Required: `flush`=1, `pc_write`=1, `branch_bubble`=0 that cycle; next cycle IDLE with default outputs.
- **MDU handshake:**
  - Stimulus: `id_is_mdu`, then `mdu_done` on cycle 5.
  - Required: `mdu_start` high for 1 cycle only; `hazard`=1 for cycles 0..5; `pc_write`=1 on cycle 6; `mdu_err`=0.
- **MDU timeout, MDU_TIMEOUT=8:**
  - Stimulus: no `mdu_done`.
  - Required: `mdu_err` rises after 8 wait cycles and stays 1; FSM returns to IDLE.
  - Repeat with `mdu_done` coincident with the timeout: `mdu_err` stays 0.
- **Reset mid-MDU_WAIT and priority:**
  - Stimulus: drop `rst_n`.
  - Required: all outputs 0 immediately, `state`=0.
  - After release, present load-use and `id_is_mdu` together: load-use wins, and `mdu_start` is not asserted.
